// File: rtl/fault_fsm_pkg.sv
// Shared types and constants for the battery-pack fault supervisor.
// Latency: none (declarations only).
// Backpressure: none.
package fault_fsm_pkg;

    // Supervisor states; the encoding is visible on the state output port.
    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        WARNING  = 2'b01,
        FAULT    = 2'b10,
        SHUTDOWN = 2'b11
    } fsm_state_t;

    // Bit positions inside fault_flags {IMB,OC,OT,UV,OV}.
    localparam int FLAG_OV   = 0;
    localparam int FLAG_UV   = 1;
    localparam int FLAG_OT   = 2;
    localparam int FLAG_OC   = 3;
    localparam int FLAG_IMB  = 4;
    localparam int NUM_FLAGS = 5;

    // First-fault codes, listed in priority order (OV highest).
    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_OV   = 3'd1;
    localparam logic [2:0] CODE_UV   = 3'd2;
    localparam logic [2:0] CODE_OT   = 3'd3;
    localparam logic [2:0] CODE_OC   = 3'd4;
    localparam logic [2:0] CODE_IMB  = 3'd5;

endpackage

// File: rtl/fault_cell_scan.sv
// Per-cell threshold scan: ov/uv/ot, voltage max/min and unmasked count over unmasked cells.
// Latency: purely combinational.
// Backpressure: none; evaluates the current inputs every cycle.
module fault_cell_scan
    import fault_fsm_pkg::*;
#(
    parameter int N_CELLS = 4,
    parameter int V_W     = 16,
    parameter int T_W     = 8,
    parameter int OV_MV   = 4200,
    parameter int UV_MV   = 2800,
    parameter int OT_C    = 60
) (
    input  logic [N_CELLS-1:0][V_W-1:0]     cell_voltage,
    input  logic [N_CELLS-1:0][T_W-1:0]     temp_flag,
    input  logic [N_CELLS-1:0]              mask,
    output logic                            ov,
    output logic                            uv,
    output logic                            ot,
`ifdef FAULT_LOG_EN
    output logic [$clog2(N_CELLS)-1:0]      ov_idx,
    output logic [$clog2(N_CELLS)-1:0]      uv_idx,
    output logic [$clog2(N_CELLS)-1:0]      ot_idx,
`endif
    output logic [V_W-1:0]                  v_max,
    output logic [V_W-1:0]                  v_min,
    output logic [$clog2(N_CELLS+1)-1:0]    n_unmasked
);

    localparam int IDX_W = $clog2(N_CELLS);
    localparam int CNT_W = $clog2(N_CELLS + 1);

    localparam logic [V_W-1:0] OV_V = V_W'(OV_MV);
    localparam logic [V_W-1:0] UV_V = V_W'(UV_MV);
    localparam logic [T_W-1:0] OT_T = T_W'(OT_C);

    // Walk the cells low to high; the first hit of each kind fixes its index.
    always_comb begin
        ov         = 1'b0;
        uv         = 1'b0;
        ot         = 1'b0;
        v_max      = '0;
        v_min      = '1;
        n_unmasked = '0;
`ifdef FAULT_LOG_EN
        ov_idx     = '0;
        uv_idx     = '0;
        ot_idx     = '0;
`endif
        for (int i = 0; i < N_CELLS; i++) begin
            if (!mask[i]) begin
                n_unmasked = n_unmasked + CNT_W'(1);
                if (cell_voltage[i] > v_max) v_max = cell_voltage[i];
                if (cell_voltage[i] < v_min) v_min = cell_voltage[i];
`ifdef FAULT_LOG_EN
                if (cell_voltage[i] > OV_V && !ov) ov_idx = IDX_W'(i);
                if (cell_voltage[i] < UV_V && !uv) uv_idx = IDX_W'(i);
                if (temp_flag[i] > OT_T && !ot)    ot_idx = IDX_W'(i);
`endif
                if (cell_voltage[i] > OV_V) ov = 1'b1;
                if (cell_voltage[i] < UV_V) uv = 1'b1;
                if (temp_flag[i] > OT_T)    ot = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fault_fsm_param.sv
// N-cell pack fault supervisor (Moore FSM with persistence/recovery counters); FAULT_LOG_EN adds a first-fault log.
// Latency: flags and state update one clk edge after the inputs are sampled.
// Backpressure: none; inputs are sampled every cycle, clear is a level.
module fault_fsm_param
    import fault_fsm_pkg::*;
#(
    parameter int N_CELLS        = 4,
    parameter int V_W            = 16,
    parameter int I_W            = 16,
    parameter int T_W            = 8,
    parameter int OV_MV          = 4200,
    parameter int UV_MV          = 2800,
    parameter int OT_C           = 60,
    parameter int OC_MA          = 1000,
    parameter int IMB_MV         = 100,
    parameter int FAULT_CYCLES   = 3,
    parameter int SHUT_CYCLES    = 6,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_CELLS-1:0][V_W-1:0]     cell_voltage,
    input  logic [I_W-1:0]                  current,
    input  logic [N_CELLS-1:0][T_W-1:0]     temp_flag,
    input  logic [N_CELLS-1:0]              mask,
    input  logic                            clear,
    output logic [1:0]                      state,
    output logic                            shutdown_signal,
    output logic [NUM_FLAGS-1:0]            fault_flags,
    output logic [2:0]                      first_fault_code,
    output logic [$clog2(N_CELLS)-1:0]      first_fault_cell
);

    localparam int IDX_W  = $clog2(N_CELLS);
    localparam int CNT_W  = $clog2(N_CELLS + 1);
    localparam int FCNT_W = $clog2(SHUT_CYCLES + 1);
    localparam int CCNT_W = $clog2(RECOVER_CYCLES + 1);

    localparam logic [V_W-1:0]    IMB_V     = V_W'(IMB_MV);
    localparam logic [I_W-1:0]    OC_I      = I_W'(OC_MA);
    localparam logic [FCNT_W-1:0] FAULT_LIM = FCNT_W'(FAULT_CYCLES);
    localparam logic [FCNT_W-1:0] SHUT_LIM  = FCNT_W'(SHUT_CYCLES);
    localparam logic [CCNT_W-1:0] REC_LIM   = CCNT_W'(RECOVER_CYCLES);

    fsm_state_t            state_q, state_d;
    logic [FCNT_W-1:0]     flt_cnt, flt_cnt_next;
    logic [CCNT_W-1:0]     clean_cnt, clean_cnt_next;
    logic [NUM_FLAGS-1:0]  raw;
    logic                  any_raw;

    logic                  ov, uv, ot;
    logic [V_W-1:0]        v_max, v_min;
    logic [CNT_W-1:0]      n_unmasked;
`ifdef FAULT_LOG_EN
    logic [IDX_W-1:0]      ov_idx, uv_idx, ot_idx;
`endif

    fault_cell_scan #(
        .N_CELLS (N_CELLS),
        .V_W     (V_W),
        .T_W     (T_W),
        .OV_MV   (OV_MV),
        .UV_MV   (UV_MV),
        .OT_C    (OT_C)
    ) u_scan (
        .cell_voltage (cell_voltage),
        .temp_flag    (temp_flag),
        .mask         (mask),
        .ov           (ov),
        .uv           (uv),
        .ot           (ot),
`ifdef FAULT_LOG_EN
        .ov_idx       (ov_idx),
        .uv_idx       (uv_idx),
        .ot_idx       (ot_idx),
`endif
        .v_max        (v_max),
        .v_min        (v_min),
        .n_unmasked   (n_unmasked)
    );

    // Raw fault vector from this cycle's inputs; imbalance needs two or more live cells.
    always_comb begin
        raw           = '0;
        raw[FLAG_OV]  = ov;
        raw[FLAG_UV]  = uv;
        raw[FLAG_OT]  = ot;
        raw[FLAG_OC]  = current > OC_I;
        raw[FLAG_IMB] = (n_unmasked > CNT_W'(1)) && ((v_max - v_min) > IMB_V);
        any_raw       = |raw;
    end

    // Persistence counters: faulty run length (saturating) and clean run length inside FAULT.
    always_comb begin
        flt_cnt_next   = '0;
        clean_cnt_next = '0;
        if (any_raw) begin
            flt_cnt_next = (flt_cnt >= SHUT_LIM) ? SHUT_LIM : flt_cnt + FCNT_W'(1);
        end
        if (state_q == FAULT && !any_raw) begin
            clean_cnt_next = (clean_cnt >= REC_LIM) ? REC_LIM : clean_cnt + CCNT_W'(1);
        end
    end

    // Next-state decision: at most one step per edge, driven by post-update counts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: begin
                if (any_raw) state_d = WARNING;
            end
            WARNING: begin
                if (!any_raw)                       state_d = NORMAL;
                else if (flt_cnt_next >= FAULT_LIM) state_d = FAULT;
            end
            FAULT: begin
                if (flt_cnt_next >= SHUT_LIM)        state_d = SHUTDOWN;
                else if (clean_cnt_next >= REC_LIM)  state_d = NORMAL;
            end
            SHUTDOWN: begin
                if (clear && !any_raw) state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= NORMAL;
        else        state_q <= state_d;
    end

    // Counter and flag registers; any return to NORMAL starts the counters afresh.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flt_cnt     <= '0;
            clean_cnt   <= '0;
            fault_flags <= '0;
        end else begin
            flt_cnt     <= (state_d == NORMAL) ? '0 : flt_cnt_next;
            clean_cnt   <= (state_d == FAULT) ? clean_cnt_next : '0;
            fault_flags <= raw;
        end
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        state           = state_q;
        shutdown_signal = (state_q == SHUTDOWN);
    end

`ifdef FAULT_LOG_EN
    logic             log_held;
    logic [2:0]       log_code, new_code;
    logic [IDX_W-1:0] log_cell, new_cell;

    // Highest-priority active fault and the lowest unmasked cell that shows it.
    always_comb begin
        new_code = CODE_IMB;
        new_cell = '0;
        if (raw[FLAG_OV]) begin
            new_code = CODE_OV;
            new_cell = ov_idx;
        end else if (raw[FLAG_UV]) begin
            new_code = CODE_UV;
            new_cell = uv_idx;
        end else if (raw[FLAG_OT]) begin
            new_code = CODE_OT;
            new_cell = ot_idx;
        end else if (raw[FLAG_OC]) begin
            new_code = CODE_OC;
        end
    end

    // Log captures the first NORMAL->WARNING cause and holds until reset or an accepted clear.
    always_ff @(posedge clk) begin
        if (!reset || (state_q == SHUTDOWN && state_d == NORMAL)) begin
            log_held <= 1'b0;
            log_code <= CODE_NONE;
            log_cell <= '0;
        end else if (state_q == NORMAL && state_d == WARNING && !log_held) begin
            log_held <= 1'b1;
            log_code <= new_code;
            log_cell <= new_cell;
        end
    end

    assign first_fault_code = log_code;
    assign first_fault_cell = log_cell;
`else
    assign first_fault_code = CODE_NONE;
    assign first_fault_cell = '0;
`endif

endmodule

// File: tb/tb_fault_fsm_param.sv
// Randomized and directed self-checking bench for fault_fsm_param against a run-length reference model.
// Latency: expects outputs one edge after inputs are applied.
// Backpressure: none; one input vector per clock.
module tb_fault_fsm_param;

    localparam int OV = 4200, UV = 2800, OT = 60, OC = 1000, IMB = 100;
    localparam int N_FAULT = 3, N_SHUT = 6, N_REC = 4;
    localparam int S_NORMAL = 0, S_WARNING = 1, S_FAULT = 2, S_SHUTDOWN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             clear;
    logic [3:0][15:0] cv;
    logic [15:0]      cur;
    logic [3:0][7:0]  tf;
    logic [3:0]       mask;
    logic [1:0]       st;
    logic             shut;
    logic [4:0]       flags;
    logic [2:0]       ffc;
    logic [1:0]       ffcell;

    logic [7:0][15:0] cv8;
    logic [7:0][7:0]  tf8;
    logic [7:0]       mask8;
    logic [15:0]      cur8;
    logic [1:0]       st8;
    logic             shut8;
    logic [4:0]       flags8;
    logic [2:0]       ffc8;
    logic [2:0]       ffcell8;

    fault_fsm_param dut (
        .clk(clk), .reset(rst_n), .cell_voltage(cv), .current(cur), .temp_flag(tf),
        .mask(mask), .clear(clear), .state(st), .shutdown_signal(shut),
        .fault_flags(flags), .first_fault_code(ffc), .first_fault_cell(ffcell)
    );

    fault_fsm_param #(.N_CELLS(8)) dut8 (
        .clk(clk), .reset(rst_n), .cell_voltage(cv8), .current(cur8), .temp_flag(tf8),
        .mask(mask8), .clear(clear), .state(st8), .shutdown_signal(shut8),
        .fault_flags(flags8), .first_fault_code(ffc8), .first_fault_cell(ffcell8)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: behaviour expressed as run lengths of faulty/clean input history.
    int       m_state = S_NORMAL;
    int       f_run = 0, c_run = 0;
    bit       m_log_held = 0;
    int       m_code = 0, m_cell = 0;
    bit [4:0] m_flags = '0;

    task automatic model_eval();
        int vmax, vmin, n, v;
        int ov_c, uv_c, ot_c;
        bit f_ov, f_uv, f_ot, f_oc, f_imb, any;
        int nxt;
        vmax = -1; vmin = 1 << 30; n = 0; ov_c = -1; uv_c = -1; ot_c = -1;
        for (int i = 0; i < 4; i++) begin
            if (!mask[i]) begin
                v = int'(cv[i]);
                n++;
                if (v > vmax) vmax = v;
                if (v < vmin) vmin = v;
                if (v > OV && ov_c < 0) ov_c = i;
                if (v < UV && uv_c < 0) uv_c = i;
                if (int'(tf[i]) > OT && ot_c < 0) ot_c = i;
            end
        end
        f_ov  = ov_c >= 0;
        f_uv  = uv_c >= 0;
        f_ot  = ot_c >= 0;
        f_oc  = int'(cur) > OC;
        f_imb = (n >= 2) && (vmax - vmin > IMB);
        any   = f_ov | f_uv | f_ot | f_oc | f_imb;
        if (!rst_n) begin
            m_state = S_NORMAL; f_run = 0; c_run = 0;
            m_log_held = 0; m_code = 0; m_cell = 0; m_flags = '0;
            return;
        end
        m_flags = {f_imb, f_oc, f_ot, f_uv, f_ov};
        if (any) begin f_run++; c_run = 0; end
        else     begin f_run = 0; c_run++; end
        nxt = m_state;
        case (m_state)
            S_NORMAL:   if (any) nxt = S_WARNING;
            S_WARNING:  if (!any) nxt = S_NORMAL; else if (f_run >= N_FAULT) nxt = S_FAULT;
            S_FAULT:    if (f_run >= N_SHUT) nxt = S_SHUTDOWN; else if (c_run >= N_REC) nxt = S_NORMAL;
            default:    if (clear && !any) nxt = S_NORMAL;
        endcase
`ifdef FAULT_LOG_EN
        if (m_state == S_SHUTDOWN && nxt == S_NORMAL) begin
            m_log_held = 0; m_code = 0; m_cell = 0;
        end else if (m_state == S_NORMAL && nxt == S_WARNING && !m_log_held) begin
            m_log_held = 1;
            if (f_ov)      begin m_code = 1; m_cell = ov_c; end
            else if (f_uv) begin m_code = 2; m_cell = uv_c; end
            else if (f_ot) begin m_code = 3; m_cell = ot_c; end
            else if (f_oc) begin m_code = 4; m_cell = 0; end
            else           begin m_code = 5; m_cell = 0; end
        end
`endif
        m_state = nxt;
    endtask

    // Apply current inputs for one edge and compare every output with the model.
    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        chk("state", st, m_state);
        chk("shutdown_signal", shut, (m_state == S_SHUTDOWN));
        chk("fault_flags", flags, m_flags);
        chk("first_fault_code", ffc, m_code);
        chk("first_fault_cell", ffcell, m_cell);
    endtask

    task automatic set_nominal();
        for (int i = 0; i < 4; i++) begin cv[i] = 16'd3700; tf[i] = 8'd25; end
        cur = 16'd500; mask = 4'b0000; clear = 1'b0;
    endtask

    task automatic rand_cycle(input bit faulty);
        int nf, c;
        for (int i = 0; i < 4; i++) begin
            cv[i] = 16'($urandom_range(3650, 3750));
            tf[i] = 8'($urandom_range(20, 60));
        end
        cur = 16'($urandom_range(0, 1000));
        if (faulty) begin
            nf = $urandom_range(1, 2);
            for (int k = 0; k < nf; k++) begin
                c = $urandom_range(0, 3);
                case ($urandom_range(0, 4))
                    0: cv[c] = 16'($urandom_range(4201, 4600));
                    1: cv[c] = 16'($urandom_range(2000, 2799));
                    2: tf[c] = 8'($urandom_range(61, 120));
                    3: cur   = 16'($urandom_range(1001, 3000));
                    default: cv[c] = 16'($urandom_range(3851, 3900));
                endcase
            end
        end
        if ($urandom_range(0, 15) == 0)
            mask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        clear = ($urandom_range(0, 3) == 0);
        rst_n = ($urandom_range(0, 299) != 0);
    endtask

    initial begin
        int  run_left;
        bit  faulty;
        run_left = 0;
        faulty   = 0;
        for (int i = 0; i < 8; i++) begin cv8[i] = 16'd3700; tf8[i] = 8'd25; end
        mask8 = '0; cur8 = 16'd500;
        set_nominal();

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk("rst_state", st, 0);
        chk("rst_shutdown", shut, 0);
        chk("rst_flags", flags, 0);
        chk("rst_code", ffc, 0);
        chk("rst_cell", ffcell, 0);
        rst_n = 1'b1;

        // Eight-cell build: undervoltage on the top cell
        cv8[7] = 16'd2500;
        step();
        chk("n8_uv_flag", flags8[1], 1);
        chk("n8_flags", flags8, 5'b10010);
        chk("n8_state", st8, S_WARNING);
`ifdef FAULT_LOG_EN
        chk("n8_code", ffc8, 2);
        chk("n8_cell", ffcell8, 7);
`else
        chk("n8_code_tied", ffc8, 0);
        chk("n8_cell_tied", ffcell8, 0);
`endif
        cv8[7] = 16'd3700;

        // Quiet pack for 20 cycles
        repeat (20) step();
        chk("quiet_state", st, S_NORMAL);
        chk("quiet_flags", flags, 0);
        chk("quiet_shutdown", shut, 0);

        // Single-cycle spike
        cv[1] = 16'd4500;
        step();
        chk("spike_warn", st, S_WARNING);
        chk("spike_ov", flags[0], 1);
        cv[1] = 16'd3700;
        step();
        chk("spike_back", st, S_NORMAL);
        chk("spike_ov_gone", flags[0], 0);
`ifdef FAULT_LOG_EN
        chk("spike_code", ffc, 1);
        chk("spike_cell", ffcell, 1);
`endif

        // Held multi-fault escalates to SHUTDOWN
        cv[1] = 16'd4500; tf[2] = 8'd90; cur = 16'd1200;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) chk("esc_warn_e1", st, S_WARNING);
            if (k == 3) chk("esc_fault_e3", st, S_FAULT);
            if (k == 6) chk("esc_shut_e6", st, S_SHUTDOWN);
        end
        set_nominal();
        repeat (10) step();
        chk("shut_sticky", st, S_SHUTDOWN);
        chk("shut_signal", shut, 1);
        clear = 1'b1;
        step();
        chk("clear_release", st, S_NORMAL);
        chk("clear_log", ffc, 0);
        clear = 1'b0;

        // Imbalance fault and timed recovery
        cv[3] = 16'd3900;
        repeat (3) step();
        chk("imb_fault_e3", st, S_FAULT);
        step();
        set_nominal();
        repeat (3) step();
        chk("imb_still_fault", st, S_FAULT);
        step();
        chk("imb_recovered", st, S_NORMAL);
`ifdef FAULT_LOG_EN
        chk("imb_code", ffc, 5);
        chk("imb_cell", ffcell, 0);
`endif

        // Masked cell ignored, unmask takes effect immediately
        cv[1] = 16'd4500; mask = 4'b0010;
        repeat (3) step();
        chk("mask_state", st, S_NORMAL);
        chk("mask_flags", flags, 0);
        mask = 4'b0000;
        step();
        chk("unmask_warn", st, S_WARNING);
        set_nominal();
        step();

        // Thresholds are strict
        for (int i = 0; i < 4; i++) begin cv[i] = 16'd4200; tf[i] = 8'd60; end
        cur = 16'd1000;
        step();
        chk("edge_ov_ot_oc", flags, 0);
        for (int i = 0; i < 4; i++) cv[i] = 16'd2800;
        step();
        chk("edge_uv", flags, 0);
        set_nominal();
        cv[3] = 16'd3800;
        step();
        chk("edge_imb", flags, 0);
        cv[3] = 16'd3900; mask = 4'b1110;
        step();
        chk("imb_single_cell", flags, 0);
        mask = 4'b0110;
        step();
        chk("imb_two_cells", flags, 5'b10000);
        set_nominal();
        step();

        // Reset in the middle of SHUTDOWN with a fault still present
        cur = 16'd1200;
        repeat (6) step();
        chk("pre_rst_shut", st, S_SHUTDOWN);
        rst_n = 1'b0;
        step();
        chk("rst_shut_state", st, S_NORMAL);
        chk("rst_shut_flags", flags, 0);
        rst_n = 1'b1;
        step();
        step();
        chk("rst_cnt_cleared", st, S_WARNING);
        step();
        chk("rst_cnt_fault", st, S_FAULT);

        // Randomized bursts of faulty and clean cycles
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (run_left == 0) begin
                faulty   = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 9);
            end
            run_left--;
            rand_cycle(faulty);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
